// File: rtl/mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// MEM-stage data-memory controller for a 16-bit asynchronous SRAM. A 32-bit
// word load or store from the EXE/MEM register is split into two half-word
// accesses (low half first). Each half-word access is held for WAIT_CYCLES+1
// cycles. While an access is in flight, ready is low. The top level freezes
// every pipeline register with ~ready.
//
// Optional feature macro: SRAM_LAST_READ_BYPASS_EN
//   When defined, the controller remembers the word of the last completed
//   load. A repeated load of that word completes in IDLE without touching the
//   SRAM. A store to that word, or a reset, invalidates the entry.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   rd_en      load request (MEM_R_EN)
//   wr_en      store request (MEM_W_EN); it wins when rd_en is also set
//   address    byte address (ALU_result); bits [1:0] are ignored
//   wr_data    store data (Val_Rm)
//   rd_data    load data, registered; valid from DONE until the next load
//   ready      0 = stall the pipeline (combinational)
//   sram_dq    bidirectional SRAM data bus
//   sram_addr  SRAM half-word address, registered
//   sram_we_n  SRAM write strobe, active low
//   sram_oe_n  SRAM output enable, active low
// -----------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               ready,
  inout  wire  [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  // One 32-bit word occupies two SRAM locations, so the word index is one
  // bit narrower than the SRAM address.
  localparam int WW = SRAM_AW - 1;
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            store_reg;
  logic [WW-1:0]   word_reg;
  logic [31:0]     wdata_reg;

  logic [31:0]     offset;
  logic [WW-1:0]   word_in;
  logic            hit;
  logic            req;
  logic            phase_last;
  logic            dq_oe;
  logic [15:0]     dq_out;

  // Out-of-range addresses simply wrap onto the SRAM word space.
  assign offset  = address - 32'(BASE_ADDR);
  assign word_in = WW'(offset >> 2);

`ifdef SRAM_LAST_READ_BYPASS_EN
  logic            tag_valid_reg;
  logic [WW-1:0]   tag_word_reg;

  assign hit = rd_en & ~wr_en & tag_valid_reg & (tag_word_reg == word_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_reg <= 1'b0;
      tag_word_reg  <= '0;
    end else begin
      if (state_reg == IDLE && req && wr_en && tag_word_reg == word_in) begin
        tag_valid_reg <= 1'b0;
      end else if (state_reg == HIGH && phase_last && !store_reg) begin
        // The load completes its last capture here, so the entry becomes
        // usable starting from the next IDLE.
        tag_valid_reg <= 1'b1;
        tag_word_reg  <= word_reg;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  // A bypass hit is not a request: it never leaves IDLE.
  assign req        = (rd_en | wr_en) & ~hit;
  assign phase_last = (cnt_reg == CNT_LAST);

  // Next-state logic and combinational outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    dq_oe      = 1'b0;
    dq_out     = wdata_reg[15:0];

    case (state_reg)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_next = LOW;
          cnt_next   = '0;
        end
      end
      LOW, HIGH: begin
        if (phase_last) begin
          state_next = (state_reg == LOW) ? HIGH : DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
        if (store_reg) begin
          // The final phase cycle keeps the data on the bus with the strobe
          // already released, which gives the SRAM its data-hold time.
          sram_we_n = phase_last;
          dq_oe     = 1'b1;
          dq_out    = (state_reg == LOW) ? wdata_reg[15:0] : wdata_reg[31:16];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE: begin
        // Inputs are ignored here; the pipeline advances on DONE->IDLE.
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sram_dq = dq_oe ? dq_out : 16'hzzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      store_reg <= 1'b0;
      word_reg  <= '0;
      wdata_reg <= '0;
      rd_data   <= '0;
      sram_addr <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      case (state_reg)
        IDLE: begin
          if (req) begin
            store_reg <= wr_en;
            word_reg  <= word_in;
            wdata_reg <= wr_data;
            sram_addr <= {word_in, 1'b0};
          end
        end
        LOW: begin
          if (phase_last) begin
            sram_addr <= {word_reg, 1'b1};
            if (!store_reg) begin
              rd_data[15:0] <= sram_dq;
            end
          end
        end
        HIGH: begin
          if (phase_last && !store_reg) begin
            rd_data[31:16] <= sram_dq;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
`timescale 1ns/1ps
module tb_mem_stage_sram_ctrl;

  localparam int BASE = 1024;
  localparam int W    = 2;
  localparam int AW   = 18;
  localparam int WW   = AW - 1;
  localparam int FULL_STALL = 2 * W + 3;
`ifdef SRAM_LAST_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int HIT_STALL = BYP ? 0 : FULL_STALL;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en;
  logic [31:0]   address, wr_data;
  wire  [31:0]   rd_data;
  wire           ready;
  wire  [15:0]   sram_dq;
  wire  [AW-1:0] sram_addr;
  wire           sram_we_n, sram_oe_n;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(W),
    .SRAM_AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .address  (address),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ready    (ready),
    .sram_dq  (sram_dq),
    .sram_addr(sram_addr),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n)
  );

  // Asynchronous SRAM: drives the bus while reading, latches while we_n is low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
  assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;

  // Word-level reference model.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd;
  bit          ref_valid;
  int          ref_tag;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'((off >> 2) % 32'(1 << WW));
  endfunction

  function automatic logic [31:0] ref_read(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request and follows it to completion, checking the SRAM side
  // cycle by cycle. Returns the number of cycles ready was low.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input string name,
                       output int stall, output int exp_stall);
    int  w, k, ph, pos;
    bit  store, hit;
    w     = word_of(a);
    store = wr;
    hit   = BYP && rd && !wr && ref_valid && (ref_tag == w);
    if (store) begin
      ref_mem[w] = d;
      if (ref_tag == w) ref_valid = 1'b0;
    end else if (!hit) begin
      ref_rd    = ref_read(w);
      ref_valid = 1'b1;
      ref_tag   = w;
    end
    exp_stall = hit ? 0 : FULL_STALL;

    @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; wr_data = d;
    #1;
    k = 0;
    while (ready !== 1'b1 && k < 50) begin
      if (k > 0) begin
        ph  = (k - 1) / (W + 1);
        pos = (k - 1) % (W + 1);
        check({name, " sram_addr"}, 32'(sram_addr), 32'(2 * w + ph));
        check({name, " oe_n"}, 32'(sram_oe_n), store ? 32'd1 : 32'd0);
        check({name, " we_n"}, 32'(sram_we_n), (store && pos != W) ? 32'd0 : 32'd1);
        if (store) check({name, " dq"}, 32'(sram_dq), ph != 0 ? 32'(d[31:16]) : 32'(d[15:0]));
      end
      @(negedge clk);
      #1;
      k++;
    end
    stall = k;
    check({name, " end we_n"}, 32'(sram_we_n), 32'd1);
    check({name, " end oe_n"}, 32'(sram_oe_n), 32'd1);
    if (store) begin
      check({name, " mem lo"}, 32'(sram_mem[2 * w]), 32'(d[15:0]));
      check({name, " mem hi"}, 32'(sram_mem[2 * w + 1]), 32'(d[31:16]));
    end
    $display("op %-10s rd=%0d wr=%0d addr=0x%08h data=0x%08h stall=%0d rd_data=0x%08h",
             name, rd, wr, a, d, stall, rd_data);
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      #1;
      check({name, " ready"}, 32'(ready), 32'd1);
      check({name, " we_n"}, 32'(sram_we_n), 32'd1);
      check({name, " oe_n"}, 32'(sram_oe_n), 32'd1);
      check({name, " rd_data"}, rd_data, ref_rd);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
    logic [31:0] exp_rd;
    int          exp_stall;
    string       name;
  } vec_t;

  vec_t vt [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, est;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;

    vt[0] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 0, 32'h0,        FULL_STALL, "st1024"};
    vt[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        1, 32'h12345678, FULL_STALL, "ld1024"};
    vt[2] = '{1'b1, 1'b0, 32'd1025, 32'h0,        1, 32'h12345678, HIT_STALL,  "ld1024rep"};
    vt[3] = '{1'b0, 1'b1, 32'd1024, 32'h0BADF00D, 0, 32'h12345678, FULL_STALL, "st1024b"};
    vt[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        1, 32'h0BADF00D, FULL_STALL, "ld1024b"};
    vt[5] = '{1'b0, 1'b1, 32'd1028, 32'hCAFEBABE, 0, 32'h0BADF00D, FULL_STALL, "st1028"};
    vt[6] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1, 32'hCAFEBABE, FULL_STALL, "ld1028b2b"};
    vt[7] = '{1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1, 32'hCAFEBABE, FULL_STALL, "rdwr1032"};
    vt[8] = '{1'b1, 1'b0, 32'd1032, 32'h0,        0, 32'hA5A55A5A, FULL_STALL, "ld1032"};
    vt[9] = '{1'b1, 1'b0, 32'd1024 + (32'd1 << (WW + 2)), 32'h0, 1, 32'h0BADF00D, FULL_STALL, "ldwrap"};

    ref_rd = 32'h0; ref_valid = 1'b0; ref_tag = -1;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; wr_data = 32'h0;
    repeat (3) @(negedge clk);
    check("reset rd_data", rd_data, 32'h0);
    check("reset ready", 32'(ready), 32'd1);
    check("reset sram_addr", 32'(sram_addr), 32'h0);
    check("reset we_n", 32'(sram_we_n), 32'd1);
    check("reset oe_n", 32'(sram_oe_n), 32'd1);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, vt[i].name, st, est);
      check({vt[i].name, " stall"}, 32'(st), 32'(vt[i].exp_stall));
      check({vt[i].name, " rd_data"}, rd_data, vt[i].exp_rd);
      if (vt[i].gap > 0) idle(vt[i].gap, {vt[i].name, " hold"});
    end

    // Twenty quiet cycles.
    idle(20, "quiet");
    $display("quiet 20 cycles done");

    // Reset in the middle of the HIGH phase of a load.
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024;
    repeat (4) @(negedge clk);
    #1;
    check("rstmid in HIGH", 32'(sram_addr), 32'd1);
    rst = 1'b1; rd_en = 1'b0;
    #1;
    check("rstmid ready", 32'(ready), 32'd1);
    check("rstmid rd_data", rd_data, 32'h0);
    check("rstmid sram_addr", 32'(sram_addr), 32'h0);
    check("rstmid we_n", 32'(sram_we_n), 32'd1);
    check("rstmid oe_n", 32'(sram_oe_n), 32'd1);
    $display("reset mid-load applied");
    @(negedge clk);
    rst = 1'b0;
    ref_rd = 32'h0; ref_valid = 1'b0;
    idle(1, "post-rst");

    // Randomized traffic checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = 32'(BASE) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = a + (32'd1 << (WW + 2));
      do_op(kind != 1, kind != 0, a, $urandom, "rand", st, est);
      check("rand stall", 32'(st), 32'(est));
      check("rand rd_data", rd_data, ref_rd);
      idle($urandom_range(0, 2), "rand idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
